ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives the PS/2 keyboard serial stream and turns set-2 make/break scan codes into held-key level signals. It sits at the keyboard pins and drives the raw level inputs of the input manager: `key_left`, `key_right`, `key_down`, `key_rotate_cw`, `key_rotate_ccw`, `key_drop` and `key_hold`. The input manager owns all edge detection and auto-repeat. This block only reports, at all times, whether each game key is physically held.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYCLES`, 20000: maximum `clk` cycles between falling edges inside a frame (200 µs at 100 MHz).
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ps2_clk` in 1: keyboard clock, asynchronous.
- `ps2_data` in 1: keyboard data, asynchronous.
- `key_left`, `key_right`, `key_down`, `key_rotate_cw`, `key_rotate_ccw`, `key_drop`, `key_hold` out 1 each: registered held levels.
- `scan_valid` out 1: one-cycle pulse for each accepted byte.
- `scan_code` out 8: last accepted byte. Held until the next accepted byte.
- `frame_err` out 1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Input conditioning:**
  - Both pins pass through a 2-FF synchronizer.
  - `ps2_clk` is additionally filtered: the filtered level changes only after `FILTER_LEN` equal samples.
  - A falling edge is a filtered 1→0 transition. `ps2_data` is sampled (synchronized) on that edge.
- **Frame receiver FSM:**
  - States: `IDLE`, `DATA`, `PARITY`, `STOP`.
  - `IDLE`: an edge with data=0 goes to `DATA` with bit counter 0. An edge with data=1 pulses `frame_err` and stays in `IDLE`.
  - `DATA`: 8 bits are shifted in LSB first. After the 8th bit, go to `PARITY`.
  - `PARITY`: the edge captures the parity bit. Go to `STOP`.
  - `STOP`: the edge captures the stop bit. The byte is accepted if parity is odd over data plus parity and stop=1. Otherwise pulse `frame_err`. Return to `IDLE` in both cases.
- **Timeout:** in any state other than `IDLE`, if `TIMEOUT_CYCLES` cycles pass with no edge, pulse `frame_err` and return to `IDLE`. The counter resets on every edge.
- **Decoder prefix flags:** `ext` and `brk`.
  - Byte 0xE0 sets `ext`.
  - Byte 0xF0 sets `brk`.
  - Any other byte is looked up against the current `{ext, brk}` and then clears both flags.
  - Any `frame_err` also clears both flags.
- **Key map (set 2):**
  - left = E0 6B
  - right = E0 74
  - down = E0 72
  - rotate_cw = E0 75 (up arrow) or 22 (X)
  - rotate_ccw = 1A (Z)
  - drop = 29 (space)
  - hold = 21 (C)
- **Level updates:**
  - A make code (`brk`=0) sets the key's level to 1. A break code (`brk`=1) sets it to 0.
  - rotate_cw is the OR of two internal held bits, one for up and one for X.
  - A byte that matches only with the wrong `ext` value is ignored. For example, 6B without E0 (keypad 4) does not drive left.
  - Unmapped bytes have no effect on levels. This includes AA, FA, EE, E1 and the E0 12 fake-shift sequence.
- Typematic repeats of a make code leave the level at 1 with no glitch.
- A break for a key that is not held leaves its level at 0.

## Timing
- **Reset:**
  - All outputs are 0. `scan_code` is 0x00.
  - FSM is in `IDLE`; `ext` and `brk` are 0; the timeout counter is 0; filter and synchronizer registers are 1, which is the bus idle level.
  - Asserting `rst_n` mid-frame discards the partial byte immediately. A frame already in flight after reset release is rejected by start-bit or stop-bit checks, or by timeout.
- **Latency:**
  - Up to 2 synchronizer cycles plus `FILTER_LEN` cycles from the pin edge to the internal edge.
  - `scan_valid`, `scan_code` and the key level update are all registered and appear in the cycle after the internal stop-bit edge.
- Prefix bytes (E0, F0) still pulse `scan_valid`.
- **Simultaneous events:** if an edge and timeout expiry occur in the same cycle, the edge wins and no error is raised.
- `scan_valid` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `ps2_pkg` holds:
  - the scan-code constants (`SC_EXT`=8'hE0, `SC_BRK`=8'hF0 and each key code);
  - the `rx_state_t` enum.
- Sub-module `ps2_rx` contains the synchronizer, the filter, the frame FSM and the timeout. It outputs `byte_valid`, `byte_data` and `byte_err`.
- The top level holds the prefix flags, the key map and the level registers.

## Test plan
- Frame 0x1A, then frames F0 1A (valid parity) → `key_rotate_ccw` rises after the 1A stop bit and falls after the second 1A. `scan_valid` pulses 3 times.
- E0 6B, then E0 F0 6B → `key_left` goes 1, then 0. A standalone 6B leaves `key_left` at 0.
- Hold X and up together, then release up only → `key_rotate_cw` stays 1. Then release X → it goes 0.
- Frame 0x29 with even parity → `frame_err` pulses once, `key_drop` stays 0, and `scan_code` is unchanged.
- Stop `ps2_clk` after 5 bits for `TIMEOUT_CYCLES`+1 cycles → `frame_err` pulses. The next clean frame 0x21 sets `key_hold`=1.
- Glitch of `FILTER_LEN`−1 cycles on `ps2_clk` → no bit is consumed. Assert `rst_n`=0 mid-frame with `key_down`=1 → all keys are 0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder.
//   - Set-2 scan-code constants for the prefixes and every game key.
//   - rx_state_t: frame receiver states.
//   - held_t: one held bit per physical key; rotate_cw has two sources (up and X).
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  // Extended (E0-prefixed) keys
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  // Plain keys
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_C     = 8'h21;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_t;

  typedef struct packed {
    logic left;
    logic right;
    logic down;
    logic up;
    logic x;
    logic ccw;
    logic drop;
    logic hold;
  } held_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Output bundle of the PS/2 key decoder towards the input manager.
//   key_*      : held key levels
//   scan_valid : one-cycle pulse per accepted byte
//   scan_code  : last accepted byte
//   frame_err  : one-cycle pulse per rejected frame
// master = decoder (drives), slave = consumer.
interface ps2_key_decoder_if;

  logic       key_left;
  logic       key_right;
  logic       key_down;
  logic       key_rotate_cw;
  logic       key_rotate_ccw;
  logic       key_drop;
  logic       key_hold;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  modport master (
    output key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw, key_drop, key_hold,
    output scan_valid, scan_code, frame_err
  );

  modport slave (
    input key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw, key_drop, key_hold,
    input scan_valid, scan_code, frame_err
  );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk glitch filter, frame FSM and inter-edge timeout.
//   clk, rst_n  : system clock, async active-low reset
//   ps2_clk     : keyboard clock pin (asynchronous)
//   ps2_data    : keyboard data pin (asynchronous)
//   byte_valid  : combinational pulse on the stop-bit edge of a good frame
//   byte_data   : received byte, valid with byte_valid
//   byte_err    : combinational pulse on start/parity/stop/timeout error
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;

  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timeout;

  // Synchronizers reset to the bus idle level so reset release creates no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip on the FILTER_LEN-th.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  assign timeout = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = (state_q == StIdle || fall) ? '0 : tmo_q + TmoW'(1);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    // An edge takes priority over a simultaneous timeout expiry.
    if (fall) begin
      case (state_q)
        StIdle: begin
          if (!data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            byte_err = 1'b1;
          end
        end
        StData: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = data_sync_q;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // Odd parity over data plus parity bit, and stop bit must be 1.
          if (data_sync_q && (^shift_q ^ parity_q)) begin
            byte_valid = 1'b1;
          end else begin
            byte_err = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (timeout) begin
      byte_err = 1'b1;
      state_d  = StIdle;
      tmo_d    = '0;
    end
  end

  assign byte_data = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard decoder: turns make/break scan codes into held-key levels.
//   clk, rst_n : system clock, async active-low reset
//   ps2_clk    : keyboard clock pin (asynchronous)
//   ps2_data   : keyboard data pin (asynchronous)
//   keys       : output bundle (key levels, scan_valid/scan_code, frame_err)
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_key_decoder_if.master keys
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  held_t      held_q, held_d;
  logic       scan_valid_q, scan_valid_d;
  logic [7:0] scan_code_q, scan_code_d;
  logic       frame_err_q, frame_err_d;
  logic       lvl;

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    held_d       = held_q;
    scan_valid_d = 1'b0;
    scan_code_d  = scan_code_q;
    frame_err_d  = byte_err;
    lvl          = ~brk_q;
    if (byte_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      scan_valid_d = 1'b1;
      scan_code_d  = byte_data;
      if (byte_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // A code seen with the wrong ext value (e.g. keypad 4 = bare 6B) is ignored.
        if (ext_q) begin
          case (byte_data)
            SC_LEFT:  held_d.left  = lvl;
            SC_RIGHT: held_d.right = lvl;
            SC_DOWN:  held_d.down  = lvl;
            SC_UP:    held_d.up    = lvl;
            default:  ;
          endcase
        end else begin
          case (byte_data)
            SC_X:     held_d.x    = lvl;
            SC_Z:     held_d.ccw  = lvl;
            SC_SPACE: held_d.drop = lvl;
            SC_C:     held_d.hold = lvl;
            default:  ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      held_q       <= held_d;
      scan_valid_q <= scan_valid_d;
      scan_code_q  <= scan_code_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign keys.key_left       = held_q.left;
  assign keys.key_right      = held_q.right;
  assign keys.key_down       = held_q.down;
  // Up arrow and X both rotate clockwise; releasing one keeps the other's hold.
  assign keys.key_rotate_cw  = held_q.up | held_q.x;
  assign keys.key_rotate_ccw = held_q.ccw;
  assign keys.key_drop       = held_q.drop;
  assign keys.key_hold       = held_q.hold;
  assign keys.scan_valid     = scan_valid_q;
  assign keys.scan_code      = scan_code_q;
  assign keys.frame_err      = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames are driven at pin level, the reference model
// pushes the expected event per frame, and a monitor pops and compares on each DUT output pulse.
module tb_ps2_key_decoder;

  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 1000;
  localparam int unsigned HALF           = 12;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_decoder_if kif ();

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .keys    (kif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [6:0] keys;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: key id per {ext, code}; ids 0..7 = left,right,down,up,x,ccw,drop,hold.
  int         keymap[int];
  bit         held[8];
  bit         m_ext, m_brk;
  logic [7:0] m_code;

  function automatic logic [6:0] model_keys();
    // {hold, drop, ccw, cw, down, right, left}
    return {held[7], held[6], held[5], held[3] | held[4], held[2], held[1], held[0]};
  endfunction

  function automatic logic [6:0] dut_keys();
    return {kif.key_hold, kif.key_drop, kif.key_rotate_ccw, kif.key_rotate_cw,
            kif.key_down, kif.key_right, kif.key_left};
  endfunction

  function automatic void model_reset();
    foreach (held[i]) held[i] = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_code = 8'h00;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = {23'd0, m_ext, b};
      if (keymap.exists(k)) held[keymap[k]] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && (kif.scan_valid || kif.frame_err)) begin
      check("valid_err_exclusive", {31'd0, kif.scan_valid & kif.frame_err}, 32'd0);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: valid=%0b err=%0b code=%0h, expected no output",
                 kif.scan_valid, kif.frame_err, kif.scan_code);
      end else begin
        mon_e = sb.pop_front();
        check("event_is_err", {31'd0, kif.frame_err}, {31'd0, mon_e.is_err});
        check("scan_code", {24'd0, kif.scan_code}, {24'd0, mon_e.code});
        check("key_levels", {25'd0, dut_keys()}, {25'd0, mon_e.keys});
      end
    end
  end

  task automatic push_ok(input logic [7:0] b);
    model_byte(b);
    sb.push_back('{1'b0, m_code, model_keys()});
  endtask

  task automatic push_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
    sb.push_back('{1'b1, m_code, model_keys()});
  endtask

  // Data changes mid-high phase; pins are driven on the falling system-clock edge.
  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF - HALF / 2) @(negedge clk);
  endtask

  // Low pulse one sample short of the filter length.
  task automatic glitch();
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok = 1'b1,
                            input bit stop_ok = 1'b1, input int glitch_after = -1);
    logic p;
    p = ~^b;
    if (!par_ok) p = ~p;
    if (par_ok && stop_ok) push_ok(b);
    else push_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(b[i]);
      if (i == glitch_after) glitch();
    end
    ps2_bit(p);
    ps2_bit(stop_ok);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("queue_drained", sb.size(), 32'd0);
  endtask

  logic [7:0] codes[8]    = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h22, 8'h1A, 8'h29, 8'h21};
  bit         exts[8]     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] unmapped[6] = '{8'hAA, 8'hFA, 8'hEE, 8'hE1, 8'h12, 8'h6B};

  initial begin
    for (int i = 0; i < 8; i++) keymap[{23'd0, exts[i], codes[i]}] = i;
    model_reset();

    repeat (5) @(negedge clk);
    #1;
    check("reset_keys", {25'd0, dut_keys()}, 32'd0);
    check("reset_scan_code", {24'd0, kif.scan_code}, 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_keys", {25'd0, dut_keys()}, 32'd0);
    check("idle_pulses", {30'd0, kif.scan_valid, kif.frame_err}, 32'd0);

    // Z make / break
    send_frame(8'h1A);
    send_frame(8'hF0);
    send_frame(8'h1A);
    drain();
    check("ccw_released", {31'd0, kif.key_rotate_ccw}, 32'd0);

    // Left via E0, bare 6B ignored
    send_frame(8'hE0); send_frame(8'h6B);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
    send_frame(8'h6B);
    drain();
    check("left_after_bare_6b", {31'd0, kif.key_left}, 32'd0);

    // X and up together; release up keeps cw held
    send_frame(8'h22);
    send_frame(8'hE0); send_frame(8'h75);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    drain();
    check("cw_held_by_x", {31'd0, kif.key_rotate_cw}, 32'd1);
    send_frame(8'hF0); send_frame(8'h22);
    drain();
    check("cw_released", {31'd0, kif.key_rotate_cw}, 32'd0);

    // Bad parity, bad stop, bad start
    send_frame(8'h29, 1'b0);
    send_frame(8'h29, 1'b1, 1'b0);
    push_err();
    ps2_bit(1'b1);
    repeat (20) @(negedge clk);
    drain();
    check("drop_after_errors", {31'd0, kif.key_drop}, 32'd0);

    // Clock stalls after 5 bits, then a clean C
    push_err();
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'(i[0]));
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
    send_frame(8'h21);
    drain();
    check("hold_after_timeout", {31'd0, kif.key_hold}, 32'd1);

    // Short glitch mid-frame must not consume a bit
    send_frame(8'hE0);
    send_frame(8'h74, 1'b1, 1'b1, 3);
    drain();

    // Unmapped bytes, fake shift, typematic repeats, break of a key not held
    send_frame(8'hAA); send_frame(8'hFA); send_frame(8'hEE); send_frame(8'hE1);
    send_frame(8'hE0); send_frame(8'h12);
    send_frame(8'h29); send_frame(8'h29); send_frame(8'h29);
    send_frame(8'hF0); send_frame(8'h29);
    send_frame(8'hF0); send_frame(8'h1A);
    drain();

    // Reset mid-frame with down held
    send_frame(8'hE0); send_frame(8'h72);
    drain();
    check("down_held", {31'd0, kif.key_down}, 32'd1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_keys", {25'd0, dut_keys()}, 32'd0);
    check("midframe_reset_code", {24'd0, kif.scan_code}, 32'd0);
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'h29);
    drain();

    // Randomized key traffic
    for (int it = 0; it < 30; it++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 8) begin
        if (exts[k]) send_frame(8'hE0, ($urandom_range(0, 11) != 0));
        if ($urandom_range(0, 1) == 0) send_frame(8'hF0, ($urandom_range(0, 11) != 0));
        send_frame(codes[k], ($urandom_range(0, 11) != 0));
      end else begin
        send_frame(unmapped[$urandom_range(0, 5)]);
      end
    end
    drain();
    check("final_keys", {25'd0, dut_keys()}, {25'd0, model_keys()});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
